// File: rtl/cache_control_if.sv
// CPU request, storage-array and physical-memory signals of the direct-mapped cache controller.
// The controller uses the slave view; the CPU/array/memory side uses the master view.
interface cache_control_if #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_tag    = 24
);
   logic               mem_read;
   logic               mem_write;
   logic [31:0]        mem_address;
   logic               mem_resp;
   logic [s_tag-1:0]   tag_out;
   logic               valid_out;
   logic               dirty_out;
   logic [s_index-1:0] array_index;
   logic               tag_load;
   logic               valid_load;
   logic               dirty_load;
   logic               data_load;
   logic               valid_in;
   logic               dirty_in;
   logic [s_tag-1:0]   tag_in;
   logic               data_sel;
   logic               pmem_read;
   logic               pmem_write;
   logic [31:0]        pmem_address;
   logic               pmem_resp;

   modport slave (
      input  mem_read, mem_write, mem_address, tag_out, valid_out, dirty_out, pmem_resp,
      output mem_resp, array_index, tag_load, valid_load, dirty_load, data_load,
             valid_in, dirty_in, tag_in, data_sel, pmem_read, pmem_write, pmem_address
   );

   modport master (
      output mem_read, mem_write, mem_address, tag_out, valid_out, dirty_out, pmem_resp,
      input  mem_resp, array_index, tag_load, valid_load, dirty_load, data_load,
             valid_in, dirty_in, tag_in, data_sel, pmem_read, pmem_write, pmem_address
   );
endinterface

// File: rtl/cache_control.sv
// Direct-mapped write-back cache controller: tag compare, dirty-line writeback and line fill,
// driving the metadata/data array controls and the physical-memory port.
module cache_control #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_tag    = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   cache_control_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

   state_t             state, state_next;
   logic [s_tag-1:0]   tag_q;
   logic [s_index-1:0] idx_q;
   logic               write_q;

   logic [s_tag-1:0]   cpu_tag;
   logic [s_index-1:0] cpu_idx;
   logic               cpu_req;
   logic               hit;
   logic               addr_unused;

   assign cpu_tag     = bus.mem_address[31 -: s_tag];
   assign cpu_idx     = bus.mem_address[s_offset +: s_index];
   assign cpu_req     = bus.mem_read | bus.mem_write;
   assign hit         = bus.valid_out && (bus.tag_out == tag_q);
   assign addr_unused = &{1'b0, bus.mem_address[s_offset-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tag_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
      end else begin
         state <= state_next;
         // Request is captured once; CPU-side changes are ignored until mem_resp.
         if (state == IDLE && cpu_req) begin
            tag_q   <= cpu_tag;
            idx_q   <= cpu_idx;
            write_q <= bus.mem_write;
         end
      end
   end

   always_comb begin
      state_next       = state;
      bus.mem_resp     = 1'b0;
      bus.array_index  = idx_q;
      bus.tag_load     = 1'b0;
      bus.valid_load   = 1'b0;
      bus.dirty_load   = 1'b0;
      bus.data_load    = 1'b0;
      bus.valid_in     = 1'b0;
      bus.dirty_in     = 1'b0;
      bus.tag_in       = '0;
      bus.data_sel     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;

      case (state)
         IDLE: begin
            // The index follows the CPU so the arrays are already addressed when COMPARE starts.
            bus.array_index = rst_n ? cpu_idx : '0;
            if (cpu_req) state_next = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               bus.mem_resp = 1'b1;
               if (write_q) begin
                  bus.data_load  = 1'b1;
                  bus.dirty_load = 1'b1;
                  bus.dirty_in   = 1'b1;
               end
               state_next = IDLE;
            end else if (bus.valid_out && bus.dirty_out) begin
               state_next = WRITEBACK;
            end else begin
               state_next = FILL;
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {bus.tag_out, idx_q, {s_offset{1'b0}}};
            if (bus.pmem_resp) begin
               bus.dirty_load = 1'b1;
               state_next     = FILL;
            end
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {tag_q, idx_q, {s_offset{1'b0}}};
            if (bus.pmem_resp) begin
               bus.data_load  = 1'b1;
               bus.data_sel   = 1'b1;
               bus.tag_load   = 1'b1;
               bus.tag_in     = tag_q;
               bus.valid_load = 1'b1;
               bus.valid_in   = 1'b1;
               bus.dirty_load = 1'b1;
               state_next     = COMPARE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with a behavioural metadata-array model and a scoreboard
// queue of expected memory addresses, fill tags and completions.
module tb_cache_control;

   logic clk = 1'b0;
   logic rst_n;
   logic init_arrays;

   always #5 clk = ~clk;

   cache_control_if bus ();

   cache_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Metadata arrays: written at the clock edge, read combinationally at array_index.
   logic [23:0] tag_mem   [8];
   logic        valid_mem [8];
   logic        dirty_mem [8];

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (init_arrays) begin
            tag_mem[i]   <= 24'h0;
            valid_mem[i] <= 1'b0;
            dirty_mem[i] <= 1'b0;
         end
      end
      if (!init_arrays) begin
         if (bus.tag_load)   tag_mem[bus.array_index]   <= bus.tag_in;
         if (bus.valid_load) valid_mem[bus.array_index] <= bus.valid_in;
         if (bus.dirty_load) dirty_mem[bus.array_index] <= bus.dirty_in;
      end
   end

   always_comb begin
      bus.tag_out   = tag_mem[bus.array_index];
      bus.valid_out = valid_mem[bus.array_index];
      bus.dirty_out = dirty_mem[bus.array_index];
   end

   int both_cnt = 0;
   always @(negedge clk) if (bus.pmem_read && bus.pmem_write) both_cnt++;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   task automatic push(input string name, input logic [31:0] value);
      exp_t e;
      e.name  = name;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check(e.name, obs, e.value);
      end
   endtask

   task automatic wait_pmem(input int budget);
      int n = 0;
      while (!(bus.pmem_read || bus.pmem_write) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("pmem_timeout", 32'(bus.pmem_read | bus.pmem_write), 32'd1);
   endtask

   function automatic logic [31:0] loads4();
      return 32'({bus.data_load, bus.tag_load, bus.valid_load, bus.dirty_load});
   endfunction

   function automatic logic [31:0] whit5();
      return 32'({bus.data_load, bus.data_sel, bus.dirty_load, bus.dirty_in, bus.mem_resp});
   endfunction

   initial begin
      rst_n           = 1'b0;
      init_arrays     = 1'b1;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = 32'h0000_0040;
      bus.pmem_resp   = 1'b0;
      repeat (2) @(negedge clk);
      init_arrays = 1'b0;

      // Reset state: every output low, including the index during reset.
      check("rst_mem_resp",   32'(bus.mem_resp), 32'd0);
      check("rst_pmem_rw",    32'({bus.pmem_read, bus.pmem_write}), 32'd0);
      check("rst_pmem_addr",  bus.pmem_address, 32'd0);
      check("rst_loads",      loads4(), 32'd0);
      check("rst_array_idx",  32'(bus.array_index), 32'd0);
      rst_n = 1'b1;

      // Cold read miss at 0x40.
      @(negedge clk);
      bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0040;
      push("cold_fill_addr", 32'h0000_0040);
      #1 check("cold_idle_idx", 32'(bus.array_index), 32'd2);
      @(negedge clk);
      bus.mem_address = 32'hDEAD_BEE0;
      #1;
      check("cold_cmp_loads", loads4(), 32'd0);
      check("cold_cmp_resp",  32'(bus.mem_resp), 32'd0);
      check("cold_cmp_idx",   32'(bus.array_index), 32'd2);
      wait_pmem(10);
      check("cold_fill_rw", 32'({bus.pmem_read, bus.pmem_write}), 32'd2);
      pop_check(bus.pmem_address);
      repeat (2) @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1;
      check("cold_fill_loads", loads4(), 32'hF);
      check("cold_fill_vals",  32'({bus.valid_in, bus.dirty_in, bus.data_sel}), 32'b101);
      check("cold_fill_tag",   32'(bus.tag_in), 32'd0);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      check("cold_hit_resp", 32'(bus.mem_resp), 32'd1);
      check("cold_hit_nold", 32'(bus.data_load), 32'd0);
      bus.mem_read = 1'b0;
      @(negedge clk);
      check("cold_resp_pulse", 32'(bus.mem_resp), 32'd0);

      // Read hit at 0x40.
      bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0040;
      push("rd_hit_resp", 32'd1);
      #1 check("rd_hit_idle_resp", 32'(bus.mem_resp), 32'd0);
      @(negedge clk);
      pop_check(32'(bus.mem_resp));
      check("rd_hit_pmem", 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
      check("rd_hit_loads", loads4(), 32'd0);
      bus.mem_read = 1'b0;

      // Write hit at 0x44.
      @(negedge clk);
      bus.mem_write = 1'b1; bus.mem_address = 32'h0000_0044;
      @(negedge clk);
      check("wr_hit_ctrl", whit5(), 32'b10111);
      bus.mem_write = 1'b0;

      // Dirty miss at 0x1040: writeback of line 0x40, then fill of 0x1040.
      @(negedge clk);
      bus.mem_read = 1'b1; bus.mem_address = 32'h0000_1040;
      push("wb_addr",   32'h0000_0040);
      push("fill_addr", 32'h0000_1040);
      push("fill_tag",  32'h0000_0010);
      @(negedge clk);
      check("dm_cmp_loads", loads4(), 32'd0);
      wait_pmem(10);
      check("dm_wb_rw", 32'({bus.pmem_read, bus.pmem_write}), 32'd1);
      pop_check(bus.pmem_address);
      repeat (2) @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1 check("dm_wb_done", 32'({bus.dirty_load, bus.dirty_in, bus.data_load, bus.tag_load}), 32'b1000);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      check("dm_fill_rw", 32'({bus.pmem_read, bus.pmem_write}), 32'd2);
      pop_check(bus.pmem_address);
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1;
      pop_check(32'(bus.tag_in));
      check("dm_fill_loads", loads4(), 32'hF);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1 check("dm_hit_resp", 32'(bus.mem_resp), 32'd1);
      bus.mem_read = 1'b0;

      // Read and write together at the top index: handled as a write.
      @(negedge clk);
      bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.mem_address = 32'hFFFF_FFE0;
      push("top_fill_addr", 32'hFFFF_FFE0);
      push("top_fill_tag",  32'h00FF_FFFF);
      #1 check("top_idle_idx", 32'(bus.array_index), 32'd7);
      @(negedge clk);
      check("top_cmp_idx", 32'(bus.array_index), 32'd7);
      wait_pmem(10);
      pop_check(bus.pmem_address);
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1 pop_check(32'(bus.tag_in));
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1 check("top_wr_hit_ctrl", whit5(), 32'b10111);
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;

      // Stray pmem_resp while idle has no effect.
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1 check("idle_resp_loads", loads4(), 32'd0);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      check("idle_resp_state", 32'({bus.pmem_read, bus.pmem_write, bus.mem_resp}), 32'd0);

      // Reset in the middle of a fill at 0x80.
      bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0080;
      @(negedge clk);
      wait_pmem(10);
      check("mid_fill_rd", 32'(bus.pmem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rw",    32'({bus.pmem_read, bus.pmem_write}), 32'd0);
      check("mid_rst_addr",  bus.pmem_address, 32'd0);
      check("mid_rst_loads", loads4(), 32'd0);
      bus.mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_valid4", 32'(valid_mem[4]), 32'd0);
      @(negedge clk);
      bus.mem_read = 1'b1; bus.mem_address = 32'h0000_1040;
      @(negedge clk);
      check("post_rst_hit", 32'(bus.mem_resp), 32'd1);
      bus.mem_read = 1'b0;
      @(negedge clk);

      check("pmem_exclusive", 32'(both_cnt), 32'd0);
      check("sb_drained",     32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
